// File: rtl/aud_ctrl.sv
// aud_ctrl -- top-level control FSM for the audio recorder/player.
//
// Turns debounced key presses into one-cycle command pulses for the recorder
// and player, remembers the last recorded address as the playback limit,
// latches the playback configuration switches, and keeps an elapsed-seconds
// display driven by the sample-frame tick.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_key_rec/play/stop                one-cycle key-press pulses
//   i_init_done                        codec initialisation complete (level)
//   i_sample_tick                      one pulse per audio sample frame
//   i_rec_addr, i_rec_full             recorder write address / end-of-memory pulse
//   i_play_done                        player reached the end address (pulse)
//   i_speed, i_fast, i_slow_0,
//   i_slow_1, i_reverse                playback configuration switches
//   o_rec_*/o_play_*                   registered one-cycle command pulses
//   o_end_addr                         last recorded address (playback limit)
//   o_mode, o_speed, o_reverse         decoded playback configuration
//   o_state                            FSM state code
//   o_display_time                     elapsed seconds, saturating at 63
module aud_ctrl #(
   parameter int TICKS_PER_SEC = 32000,
   parameter int ADDR_W        = 20
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_stop,
   input  logic              i_init_done,
   input  logic              i_sample_tick,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic              i_rec_full,
   input  logic              i_play_done,
   input  logic [2:0]        i_speed,
   input  logic              i_fast,
   input  logic              i_slow_0,
   input  logic              i_slow_1,
   input  logic              i_reverse,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic [1:0]        o_mode,
   output logic [3:0]        o_speed,
   output logic              o_reverse,
   output logic [2:0]        o_state,
   output logic [5:0]        o_display_time
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      INIT       = 3'd0,
      IDLE       = 3'd1,
      REC        = 3'd2,
      REC_PAUSE  = 3'd3,
      PLAY       = 3'd4,
      PLAY_PAUSE = 3'd5
   } state_t;

   state_t          state;
   logic [TW-1:0]   tick_cnt;
   logic            key_stop;
   logic            key_rec;
   logic            key_play;
   logic [1:0]      mode_dec;
   logic [3:0]      speed_dec;

   // Same-cycle key priority: stop beats rec beats play, and a losing key is
   // simply dropped even if the winning key has no effect in the current state.
   assign key_stop = i_key_stop;
   assign key_rec  = i_key_rec & ~i_key_stop;
   assign key_play = i_key_play & ~i_key_stop & ~i_key_rec;

   assign o_state = state;

   // Configuration decode: fast wins over the two slow modes; the speed factor
   // only means something in a non-normal mode, so normal is pinned to 1.
   always_comb begin
      mode_dec  = 2'd0;
      speed_dec = 4'd1;
      if (i_fast) begin
         mode_dec  = 2'd1;
         speed_dec = {1'b0, i_speed} + 4'd1;
      end else if (i_slow_0) begin
         mode_dec  = 2'd2;
         speed_dec = {1'b0, i_speed} + 4'd1;
      end else if (i_slow_1) begin
         mode_dec  = 2'd3;
         speed_dec = {1'b0, i_speed} + 4'd1;
      end
   end

   // Main controller: state, command pulses, end address, configuration
   // latch and elapsed-time counter all live here so that a state change and
   // the timer clear it implies happen on the same edge. The timer update
   // comes before the case statement so a clear on PLAY/REC entry overrides it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= INIT;
         o_rec_start    <= 1'b0;
         o_rec_pause    <= 1'b0;
         o_rec_stop     <= 1'b0;
         o_play_start   <= 1'b0;
         o_play_pause   <= 1'b0;
         o_play_stop    <= 1'b0;
         o_end_addr     <= '0;
         o_mode         <= 2'd0;
         o_speed        <= 4'd1;
         o_reverse      <= 1'b0;
         tick_cnt       <= '0;
         o_display_time <= 6'd0;
      end else begin
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;

         // The player must not see its configuration change mid-stream.
         if (state != PLAY) begin
            o_mode    <= mode_dec;
            o_speed   <= speed_dec;
            o_reverse <= i_reverse;
         end

         if (i_sample_tick && (state == REC || state == PLAY)) begin
            if (tick_cnt == TICK_LAST) begin
               tick_cnt <= '0;
               if (o_display_time != 6'd63)
                  o_display_time <= o_display_time + 6'd1;
            end else begin
               tick_cnt <= tick_cnt + 1'b1;
            end
         end

         case (state)
            INIT: begin
               if (i_init_done)
                  state <= IDLE;
            end
            IDLE: begin
               if (key_rec) begin
                  state          <= REC;
                  o_rec_start    <= 1'b1;
                  tick_cnt       <= '0;
                  o_display_time <= 6'd0;
                  o_end_addr     <= '0;
               end else if (key_play && o_end_addr != '0) begin
                  state          <= PLAY;
                  o_play_start   <= 1'b1;
                  tick_cnt       <= '0;
                  o_display_time <= 6'd0;
               end
            end
            REC: begin
               // Running out of memory trumps everything, including a
               // coincident stop, and marks the whole memory as recorded.
               if (i_rec_full) begin
                  state      <= IDLE;
                  o_rec_stop <= 1'b1;
                  o_end_addr <= '1;
               end else if (key_stop) begin
                  state      <= IDLE;
                  o_rec_stop <= 1'b1;
                  o_end_addr <= i_rec_addr;
               end else if (key_rec) begin
                  state       <= REC_PAUSE;
                  o_rec_pause <= 1'b1;
               end
            end
            REC_PAUSE: begin
               if (key_stop) begin
                  state      <= IDLE;
                  o_rec_stop <= 1'b1;
                  o_end_addr <= i_rec_addr;
               end else if (key_rec) begin
                  state       <= REC;
                  o_rec_start <= 1'b1;
               end
            end
            PLAY: begin
               if (key_stop || i_play_done) begin
                  state       <= IDLE;
                  o_play_stop <= 1'b1;
               end else if (key_play) begin
                  state        <= PLAY_PAUSE;
                  o_play_pause <= 1'b1;
               end
            end
            PLAY_PAUSE: begin
               if (key_stop) begin
                  state       <= IDLE;
                  o_play_stop <= 1'b1;
               end else if (key_play) begin
                  state        <= PLAY;
                  o_play_start <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aud_ctrl.sv
// tb_aud_ctrl -- self-checking bench for aud_ctrl.
//
// Two instances share every input: dut_a uses the default 32000 ticks per
// second, dut_b uses 4 so that saturation and tick arithmetic stay short.
// A table of single-cycle vectors covers the key/state behaviour; hand-written
// sequences cover the timer, configuration hold and mid-play reset.
module tb_aud_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_rec, key_play, key_stop;
   logic        init_done, sample_tick;
   logic [19:0] rec_addr;
   logic        rec_full, play_done;
   logic [2:0]  speed;
   logic        fast, slow_0, slow_1, reverse;

   logic        a_rs, a_rp, a_rstop, a_ps, a_pp, a_pstop;
   logic [19:0] a_end;
   logic [1:0]  a_mode;
   logic [3:0]  a_speed;
   logic        a_rev;
   logic [2:0]  a_state;
   logic [5:0]  a_time;

   logic        b_rs, b_rp, b_rstop, b_ps, b_pp, b_pstop;
   logic [19:0] b_end;
   logic [1:0]  b_mode;
   logic [3:0]  b_speed;
   logic        b_rev;
   logic [2:0]  b_state;
   logic [5:0]  b_time;

   logic [5:0]  a_pulses;
   logic [5:0]  b_pulses;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] P_NONE  = 6'b000000;
   localparam logic [5:0] P_RS    = 6'b100000;
   localparam logic [5:0] P_RP    = 6'b010000;
   localparam logic [5:0] P_RSTOP = 6'b001000;
   localparam logic [5:0] P_PS    = 6'b000100;
   localparam logic [5:0] P_PP    = 6'b000010;
   localparam logic [5:0] P_PSTOP = 6'b000001;

   assign a_pulses = {a_rs, a_rp, a_rstop, a_ps, a_pp, a_pstop};
   assign b_pulses = {b_rs, b_rp, b_rstop, b_ps, b_pp, b_pstop};

   always #5 clk = ~clk;

   aud_ctrl dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
      .i_init_done(init_done), .i_sample_tick(sample_tick),
      .i_rec_addr(rec_addr), .i_rec_full(rec_full), .i_play_done(play_done),
      .i_speed(speed), .i_fast(fast), .i_slow_0(slow_0), .i_slow_1(slow_1),
      .i_reverse(reverse),
      .o_rec_start(a_rs), .o_rec_pause(a_rp), .o_rec_stop(a_rstop),
      .o_play_start(a_ps), .o_play_pause(a_pp), .o_play_stop(a_pstop),
      .o_end_addr(a_end), .o_mode(a_mode), .o_speed(a_speed),
      .o_reverse(a_rev), .o_state(a_state), .o_display_time(a_time)
   );

   aud_ctrl #(.TICKS_PER_SEC(4), .ADDR_W(20)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
      .i_init_done(init_done), .i_sample_tick(sample_tick),
      .i_rec_addr(rec_addr), .i_rec_full(rec_full), .i_play_done(play_done),
      .i_speed(speed), .i_fast(fast), .i_slow_0(slow_0), .i_slow_1(slow_1),
      .i_reverse(reverse),
      .o_rec_start(b_rs), .o_rec_pause(b_rp), .o_rec_stop(b_rstop),
      .o_play_start(b_ps), .o_play_pause(b_pp), .o_play_stop(b_pstop),
      .o_end_addr(b_end), .o_mode(b_mode), .o_speed(b_speed),
      .o_reverse(b_rev), .o_state(b_state), .o_display_time(b_time)
   );

   typedef struct {
      logic        rec;
      logic        play;
      logic        stop;
      logic        init;
      logic        full;
      logic        done;
      logic [19:0] addr;
      logic [2:0]  st;
      logic [5:0]  pulses;
      logic [19:0] end_addr;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   function automatic vec_t mkVec(input logic rec, input logic play, input logic stop,
                                  input logic init, input logic full, input logic done,
                                  input logic [19:0] addr, input logic [2:0] st,
                                  input logic [5:0] pulses, input logic [19:0] end_addr);
      vec_t v;
      v.rec = rec; v.play = play; v.stop = stop; v.init = init;
      v.full = full; v.done = done; v.addr = addr; v.st = st;
      v.pulses = pulses; v.end_addr = end_addr;
      return v;
   endfunction

   // Compare one observed value against its expected value and log failures.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one table vector's inputs; configuration and tick stay as they are.
   task automatic applyStimulus(input vec_t v);
      key_rec   = v.rec;
      key_play  = v.play;
      key_stop  = v.stop;
      init_done = v.init;
      rec_full  = v.full;
      play_done = v.done;
      rec_addr  = v.addr;
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearKeys();
      key_rec = 0; key_play = 0; key_stop = 0; rec_full = 0; play_done = 0;
   endtask

   task automatic applyReset();
      rst = 1; clearKeys(); init_done = 0; sample_tick = 0; rec_addr = '0;
      speed = 0; fast = 0; slow_0 = 0; slow_1 = 0; reverse = 0;
      cycle(); cycle();
      rst = 0;
   endtask

   initial begin
      // Key/state table, run on dut_a right after reset.
      vecs[0]  = mkVec(0,1,0, 0,0,0, 20'h0,     3'd0, P_NONE,  20'h0);
      vecs[1]  = mkVec(1,0,0, 0,0,0, 20'h0,     3'd0, P_NONE,  20'h0);
      vecs[2]  = mkVec(0,0,0, 1,0,0, 20'h0,     3'd1, P_NONE,  20'h0);
      vecs[3]  = mkVec(0,1,0, 1,0,0, 20'h0,     3'd1, P_NONE,  20'h0);
      vecs[4]  = mkVec(0,0,1, 1,0,0, 20'h0,     3'd1, P_NONE,  20'h0);
      vecs[5]  = mkVec(1,0,0, 1,0,0, 20'h0,     3'd2, P_RS,    20'h0);
      vecs[6]  = mkVec(1,0,0, 1,0,0, 20'h0,     3'd3, P_RP,    20'h0);
      vecs[7]  = mkVec(0,1,0, 1,0,0, 20'h0,     3'd3, P_NONE,  20'h0);
      vecs[8]  = mkVec(1,0,0, 1,0,0, 20'h0,     3'd2, P_RS,    20'h0);
      vecs[9]  = mkVec(0,0,1, 1,0,0, 20'h00123, 3'd1, P_RSTOP, 20'h00123);
      vecs[10] = mkVec(0,1,0, 1,0,0, 20'h0,     3'd4, P_PS,    20'h00123);
      vecs[11] = mkVec(1,0,0, 1,0,0, 20'h0,     3'd4, P_NONE,  20'h00123);
      vecs[12] = mkVec(0,1,0, 1,0,0, 20'h0,     3'd5, P_PP,    20'h00123);
      vecs[13] = mkVec(1,0,0, 1,0,0, 20'h0,     3'd5, P_NONE,  20'h00123);
      vecs[14] = mkVec(0,1,0, 1,0,0, 20'h0,     3'd4, P_PS,    20'h00123);
      vecs[15] = mkVec(0,0,0, 1,0,1, 20'h0,     3'd1, P_PSTOP, 20'h00123);
      vecs[16] = mkVec(0,1,0, 1,0,0, 20'h0,     3'd4, P_PS,    20'h00123);
      vecs[17] = mkVec(0,0,1, 1,0,0, 20'h0,     3'd1, P_PSTOP, 20'h00123);
      vecs[18] = mkVec(1,1,0, 1,0,0, 20'h0,     3'd2, P_RS,    20'h0);
      vecs[19] = mkVec(1,0,1, 1,0,0, 20'h00456, 3'd1, P_RSTOP, 20'h00456);
      vecs[20] = mkVec(1,0,0, 1,0,0, 20'h0,     3'd2, P_RS,    20'h0);
      vecs[21] = mkVec(0,0,1, 1,1,0, 20'h00789, 3'd1, P_RSTOP, 20'hFFFFF);
      vecs[22] = mkVec(0,0,0, 1,0,0, 20'h0,     3'd1, P_NONE,  20'hFFFFF);
      vecs[23] = mkVec(0,1,1, 1,0,0, 20'h0,     3'd1, P_NONE,  20'hFFFFF);
      vecs[24] = mkVec(0,1,0, 1,0,0, 20'h0,     3'd4, P_PS,    20'hFFFFF);
      vecs[25] = mkVec(0,1,1, 1,0,0, 20'h0,     3'd1, P_PSTOP, 20'hFFFFF);

      // Reset values.
      applyReset();
      checkOutput("reset state",  32'(a_state),  32'd0);
      checkOutput("reset pulses", 32'(a_pulses), 32'(P_NONE));
      checkOutput("reset end",    32'(a_end),    32'd0);
      checkOutput("reset mode",   32'(a_mode),   32'd0);
      checkOutput("reset speed",  32'(a_speed),  32'd1);
      checkOutput("reset time",   32'(a_time),   32'd0);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         cycle();
         checkOutput($sformatf("vec%0d state", i),  32'(a_state),  32'(vecs[i].st));
         checkOutput($sformatf("vec%0d pulses", i), 32'(a_pulses), 32'(vecs[i].pulses));
         checkOutput($sformatf("vec%0d end", i),    32'(a_end),    32'(vecs[i].end_addr));
      end
      clearKeys();

      // Two full seconds of recording at the default rate.
      applyReset();
      init_done = 1;
      cycle();
      key_rec = 1; cycle(); key_rec = 0;
      checkOutput("rec2s start", 32'(a_pulses), 32'(P_RS));
      sample_tick = 1;
      repeat (64000) cycle();
      sample_tick = 0;
      checkOutput("rec2s time", 32'(a_time), 32'd2);
      rec_addr = 20'h01F3F; key_stop = 1; cycle(); key_stop = 0;
      checkOutput("rec2s stop pulse", 32'(a_pulses), 32'(P_RSTOP));
      checkOutput("rec2s end",        32'(a_end),    32'h1F3F);
      checkOutput("rec2s state",      32'(a_state),  32'd1);
      checkOutput("rec2s time kept",  32'(a_time),   32'd2);
      cycle();
      checkOutput("rec2s pulse width", 32'(a_pulses), 32'(P_NONE));

      // Configuration follows the switches except while playing.
      fast = 1; speed = 3'd3; cycle();
      checkOutput("cfg idle mode",  32'(a_mode),  32'd1);
      checkOutput("cfg idle speed", 32'(a_speed), 32'd4);
      key_play = 1; cycle(); key_play = 0;
      checkOutput("cfg play pulse", 32'(a_pulses), 32'(P_PS));
      checkOutput("cfg play time",  32'(a_time),   32'd0);
      slow_0 = 1; reverse = 1; cycle(); cycle();
      checkOutput("cfg held mode",  32'(a_mode),  32'd1);
      checkOutput("cfg held speed", 32'(a_speed), 32'd4);
      checkOutput("cfg held rev",   32'(a_rev),   32'd0);
      key_play = 1; cycle(); key_play = 0;
      checkOutput("cfg pause pulse", 32'(a_pulses), 32'(P_PP));
      cycle();
      checkOutput("cfg pause mode", 32'(a_mode), 32'd1);
      checkOutput("cfg pause rev",  32'(a_rev),  32'd1);
      fast = 0; cycle();
      checkOutput("cfg slow0 mode",  32'(a_mode),  32'd2);
      checkOutput("cfg slow0 speed", 32'(a_speed), 32'd4);
      slow_0 = 0; slow_1 = 1; speed = 3'd7; cycle();
      checkOutput("cfg slow1 mode",  32'(a_mode),  32'd3);
      checkOutput("cfg slow1 speed", 32'(a_speed), 32'd8);
      slow_1 = 0; cycle();
      checkOutput("cfg normal mode",  32'(a_mode),  32'd0);
      checkOutput("cfg normal speed", 32'(a_speed), 32'd1);
      key_stop = 1; cycle(); key_stop = 0;
      checkOutput("cfg stop pulse", 32'(a_pulses), 32'(P_PSTOP));
      reverse = 0;

      // Saturation and end-of-memory on dut_b (4 ticks per second).
      applyReset();
      init_done = 1;
      cycle();
      key_rec = 1; cycle(); key_rec = 0;
      sample_tick = 1;
      repeat (252) cycle();
      checkOutput("sat at 252", 32'(b_time), 32'd63);
      repeat (48) cycle();
      sample_tick = 0;
      checkOutput("sat at 300", 32'(b_time), 32'd63);
      rec_full = 1; cycle(); rec_full = 0;
      checkOutput("full state", 32'(b_state),  32'd1);
      checkOutput("full pulse", 32'(b_pulses), 32'(P_RSTOP));
      checkOutput("full end",   32'(b_end),    32'hFFFFF);

      // Playback timer: cleared on entry, held while paused, kept on stop.
      key_play = 1; cycle(); key_play = 0;
      checkOutput("ptime state", 32'(b_state), 32'd4);
      checkOutput("ptime clear", 32'(b_time),  32'd0);
      sample_tick = 1; repeat (9) cycle(); sample_tick = 0;
      checkOutput("ptime 9 ticks", 32'(b_time), 32'd2);
      key_play = 1; cycle(); key_play = 0;
      checkOutput("ptime pause", 32'(b_state), 32'd5);
      sample_tick = 1; repeat (8) cycle(); sample_tick = 0;
      checkOutput("ptime paused hold", 32'(b_time), 32'd2);
      key_play = 1; cycle(); key_play = 0;
      checkOutput("ptime resume pulse", 32'(b_pulses), 32'(P_PS));
      sample_tick = 1; repeat (3) cycle(); sample_tick = 0;
      checkOutput("ptime 12 ticks", 32'(b_time), 32'd3);
      key_stop = 1; cycle(); key_stop = 0;
      checkOutput("ptime stop pulse", 32'(b_pulses), 32'(P_PSTOP));
      cycle();
      checkOutput("ptime stop kept", 32'(b_time), 32'd3);

      // Reset in the middle of playback wins over a coincident stop key.
      fast = 1; speed = 3'd3; reverse = 1; cycle();
      key_play = 1; cycle(); key_play = 0;
      checkOutput("mrst play state", 32'(b_state), 32'd4);
      checkOutput("mrst play mode",  32'(b_mode),  32'd1);
      sample_tick = 1; repeat (5) cycle(); sample_tick = 0;
      rst = 1; key_stop = 1; cycle();
      checkOutput("mrst state",  32'(b_state),  32'd0);
      checkOutput("mrst pulses", 32'(b_pulses), 32'(P_NONE));
      checkOutput("mrst end",    32'(b_end),    32'd0);
      checkOutput("mrst time",   32'(b_time),   32'd0);
      checkOutput("mrst mode",   32'(b_mode),   32'd0);
      checkOutput("mrst speed",  32'(b_speed),  32'd1);
      checkOutput("mrst rev",    32'(b_rev),    32'd0);
      rst = 0; key_stop = 0; cycle();
      checkOutput("mrst after pulses", 32'(b_pulses), 32'(P_NONE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
